// File: rtl/uart_cmd_seq.sv
// Host-side command sequencer for the UART register interface: packs one read/write
// request into a command word, issues it, waits for completion and returns one response.
module uart_cmd_seq #(
   parameter int CMD_WIDTH  = 16,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 1000000,
   parameter int TO_WIDTH   = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_vld,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [CMD_WIDTH-1:0]  cmd_out,
   output logic                  cmd_vld,
   input  logic                  cmd_rdy,
   input  logic                  read_rdy,
   input  logic [DATA_WIDTH:0]   read_data
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      WAIT_READ = 3'd3,
      RESP      = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CMD_WIDTH-1:0]  cmd_out_q, cmd_out_d;
   logic                  cmd_vld_q, cmd_vld_d;
   logic                  req_rdy_q, req_rdy_d;
   logic                  busy_q, busy_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
   logic                  seen_busy_q, seen_busy_d;
   logic                  to_last;

   assign to_last = (to_cnt_q == TO_WIDTH'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cmd_out_d   = cmd_out_q;
      cmd_vld_d   = cmd_vld_q;
      rsp_vld_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      to_cnt_d    = to_cnt_q;
      seen_busy_d = seen_busy_q;

      case (state_q)
         IDLE: begin
            if (req_vld && req_rdy_q) begin
               cmd_out_d = {req_wr, req_addr, req_wr ? req_wdata : {DATA_WIDTH{1'b0}}};
               cmd_vld_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_rdy) begin
               cmd_vld_d   = 1'b0;
               to_cnt_d    = '0;
               seen_busy_d = 1'b0;
               state_d     = cmd_out_q[CMD_WIDTH-1] ? WAIT_DONE : WAIT_READ;
            end
         end
         WAIT_DONE: begin
            // The UART must be seen dropping cmd_rdy before a high level means "frame done".
            seen_busy_d = seen_busy_q | ~cmd_rdy;
            if (seen_busy_q && cmd_rdy) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (to_last) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + TO_WIDTH'(1);
            end
         end
         WAIT_READ: begin
            if (read_rdy) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = read_data[DATA_WIDTH-1:0];
               rsp_err_d  = read_data[DATA_WIDTH];
               state_d    = RESP;
            end else if (to_last) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + TO_WIDTH'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            cmd_vld_d = 1'b0;
         end
      endcase

      // Handshake/status outputs are registered, so derive them from the next state.
      req_rdy_d = (state_d == IDLE);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_out_q   <= '0;
         cmd_vld_q   <= 1'b0;
         req_rdy_q   <= 1'b1;
         busy_q      <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         to_cnt_q    <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_out_q   <= cmd_out_d;
         cmd_vld_q   <= cmd_vld_d;
         req_rdy_q   <= req_rdy_d;
         busy_q      <= busy_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         to_cnt_q    <= to_cnt_d;
         seen_busy_q <= seen_busy_d;
      end
   end

   assign req_rdy  = req_rdy_q;
   assign busy     = busy_q;
   assign cmd_out  = cmd_out_q;
   assign cmd_vld  = cmd_vld_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Bench for uart_cmd_seq: directed and random transactions against a cycle-count
// reference model of the request/response behaviour.
module tb_uart_cmd_seq;

   localparam int TIMEOUT = 64;
   localparam int NEVER   = 1 << 30;

   logic       clk;
   logic       rst_n;
   logic       req_vld;
   logic       req_rdy;
   logic       req_wr;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_vld;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic [15:0] cmd_out;
   logic       cmd_vld;
   logic       cmd_rdy;
   logic       read_rdy;
   logic [8:0] read_data;

   int passed = 0;
   int total  = 0;

   uart_cmd_seq #(
      .CMD_WIDTH (16),
      .ADDR_WIDTH(7),
      .DATA_WIDTH(8),
      .TIMEOUT   (TIMEOUT),
      .TO_WIDTH  (7)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .req_wr   (req_wr),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_vld  (rsp_vld),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .cmd_out  (cmd_out),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .read_rdy (read_rdy),
      .read_data(read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      total = total + 1;
      assert (obs === 32'(exp)) passed = passed + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_rdy"}, 32'(req_rdy), 1);
      check({tag, "_cmd_vld"}, 32'(cmd_vld), 0);
      check({tag, "_cmd_out"}, 32'(cmd_out), 0);
      check({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   // One complete request/response. For a write, evt is the number of cycles the UART
   // holds cmd_rdy low after taking the command (0 = it never drops). For a read, evt is
   // the wait cycle carrying the read_rdy pulse (0 = no pulse). hold = cycles of cmd_rdy
   // back-pressure while the command is offered.
   task automatic run_txn(input bit wr, input int addr, input int wdata, input int hold,
                          input int evt, input int rdata);
      int  exp_cmd;
      int  done_k;
      int  k_exp;
      int  exp_data;
      int  exp_err;
      bit  timed_out;

      exp_cmd = (int'(wr) << 15) + (addr << 8) + (wr ? wdata : 0);
      if (evt == 0) done_k = NEVER;
      else          done_k = wr ? evt + 1 : evt;
      timed_out = (done_k > TIMEOUT);
      k_exp     = timed_out ? TIMEOUT : done_k;
      exp_data  = (timed_out || wr) ? 0 : (rdata & 255);
      exp_err   = timed_out ? 1 : (wr ? 0 : ((rdata >> 8) & 1));

      check("req_rdy_before_req", 32'(req_rdy), 1);
      req_vld   = 1'b1;
      req_wr    = wr;
      req_addr  = 7'(addr);
      req_wdata = 8'(wdata);
      cmd_rdy   = 1'($urandom_range(0, 1));
      read_rdy  = 1'($urandom_range(0, 1));
      tick();
      req_vld   = 1'b0;
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 7'($urandom_range(0, 127));
      req_wdata = 8'($urandom_range(0, 255));
      check("cmd_vld_latency", 32'(cmd_vld), 1);
      check("cmd_out_word", 32'(cmd_out), exp_cmd);
      check("req_rdy_in_flight", 32'(req_rdy), 0);
      check("busy_in_flight", 32'(busy), 1);

      for (int i = 0; i < hold; i++) begin
         cmd_rdy  = 1'b0;
         read_rdy = 1'($urandom_range(0, 1));
         req_vld  = 1'($urandom_range(0, 1));
         tick();
         check("hold_cmd_vld", 32'(cmd_vld), 1);
         check("hold_cmd_out", 32'(cmd_out), exp_cmd);
         check("hold_req_rdy", 32'(req_rdy), 0);
      end
      req_vld  = 1'b0;
      cmd_rdy  = 1'b1;
      read_rdy = 1'b0;
      tick();
      check("cmd_vld_after_xfer", 32'(cmd_vld), 0);

      for (int k = 1; k <= k_exp; k++) begin
         if (wr) begin
            cmd_rdy   = !(evt != 0 && k <= evt);
            read_rdy  = ($urandom_range(0, 2) == 0);
            read_data = 9'($urandom_range(0, 511));
         end else begin
            cmd_rdy   = 1'($urandom_range(0, 1));
            read_rdy  = (k == evt);
            read_data = (k == evt) ? 9'(rdata) : 9'($urandom_range(0, 511));
         end
         tick();
         if (k < k_exp) begin
            check("rsp_vld_quiet", 32'(rsp_vld), 0);
         end else begin
            check("rsp_vld_pulse", 32'(rsp_vld), 1);
            check("rsp_data", 32'(rsp_data), exp_data);
            check("rsp_err", 32'(rsp_err), exp_err);
         end
      end

      read_rdy  = 1'($urandom_range(0, 1));
      read_data = 9'($urandom_range(0, 511));
      tick();
      read_rdy = 1'b0;
      check("rsp_vld_one_cycle", 32'(rsp_vld), 0);
      check("req_rdy_after_rsp", 32'(req_rdy), 1);
      check("busy_after_rsp", 32'(busy), 0);
      check("rsp_data_held", 32'(rsp_data), exp_data);
      check("rsp_err_held", 32'(rsp_err), exp_err);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      cmd_rdy   = 1'b1;
      read_rdy  = 1'b0;
      read_data = '0;

      tick();
      tick();
      check_reset_outputs("por");
      rst_n = 1'b1;
      tick();
      check("req_rdy_after_por", 32'(req_rdy), 1);

      // Directed write: 200 busy cycles exceeds the 64-cycle guard, 40 does not.
      run_txn(1'b1, 'h12, 'hA5, 0, 40, 0);
      run_txn(1'b1, 'h12, 'hA5, 0, 200, 0);

      // Directed reads, including the parity-error case.
      run_txn(1'b0, 'h05, 'h00, 0, 10, 'h03C);
      run_txn(1'b0, 'h7F, 'h00, 2, 5, 'h1FF);

      // Timeout boundaries on both wait states.
      run_txn(1'b0, 'h21, 'h00, 0, 0, 0);
      run_txn(1'b0, 'h22, 'h00, 0, TIMEOUT, 'h0C3);
      run_txn(1'b0, 'h23, 'h00, 0, TIMEOUT + 1, 'h0C3);
      run_txn(1'b1, 'h24, 'h5A, 0, 0, 0);
      run_txn(1'b1, 'h25, 'h5A, 0, TIMEOUT - 1, 0);
      run_txn(1'b1, 'h26, 'h5A, 0, TIMEOUT, 0);

      // Back-pressure then back-to-back W,R,W with stray read_rdy during the writes.
      run_txn(1'b1, 'h31, 'h11, 30, 3, 0);
      run_txn(1'b0, 'h32, 'h00, 0, 7, 'h077);
      run_txn(1'b1, 'h33, 'h22, 0, 1, 0);

      // Reset in the middle of a read wait.
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 7'h33;
      tick();
      req_vld = 1'b0;
      cmd_rdy = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      check("busy_before_reset", 32'(busy), 1);
      rst_n     = 1'b0;
      read_rdy  = 1'b1;
      read_data = 9'h055;
      tick();
      check_reset_outputs("mid_rst1");
      tick();
      check_reset_outputs("mid_rst2");
      rst_n    = 1'b1;
      read_rdy = 1'b0;
      tick();
      check("rel_req_rdy", 32'(req_rdy), 1);
      check("rel_rsp_vld", 32'(rsp_vld), 0);
      check("rel_cmd_vld", 32'(cmd_vld), 0);

      // Randomised traffic.
      for (int n = 0; n < 25; n++) begin
         bit wr_r;
         int evt_r;
         wr_r = 1'($urandom_range(0, 1));
         evt_r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
         run_txn(wr_r, int'($urandom_range(0, 127)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 5)), evt_r, int'($urandom_range(0, 511)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
